// File: rtl/vram_sched.sv
// vram_sched: single-port scheduler for the VRAM planes shared by VDP fetch, CPU access and the clear sweep.
//   Optional feature macro: SCHED_FAIR_EN (CPU starvation guard against the clear sweep).
//   Ports:
//     clk, reset_n                 clock, async active-low reset
//     vdp_req/vdp_addr -> vdp_ack/vdp_data       VDP fetch, all plane bytes (plane0 in [7:0])
//     cpu_req/cpu_wr/cpu_addr/cpu_din -> cpu_ack/cpu_dout   CPU access via rd_bank/wr_bank
//     clr_start -> clr_busy        clear sweep writing CLR_VAL to every address of every plane
//     mem_addr/mem_din/mem_we -> mem_q          registered shared plane port, 1-cycle read latency
module vram_sched #(
  parameter int         ADDR_W  = 13,
  parameter int         NPLANE  = 6,
  parameter logic [7:0] CLR_VAL = 8'h00
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vdp_req,
  input  logic [ADDR_W-1:0]   vdp_addr,
  output logic                vdp_ack,
  output logic [8*NPLANE-1:0] vdp_data,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [7:0]          cpu_din,
  input  logic [7:0]          rd_bank,
  input  logic [7:0]          wr_bank,
  output logic                cpu_ack,
  output logic [7:0]          cpu_dout,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_din,
  output logic [NPLANE-1:0]   mem_we,
  input  logic [8*NPLANE-1:0] mem_q
);
  localparam logic [1:0] SRC_NONE = 2'd0, SRC_VDP = 2'd1, SRC_CPU = 2'd2, SRC_CLR = 2'd3;
  logic                vdp_out_q, vdp_out_d, cpu_out_q, cpu_out_d;
  logic                clr_busy_q, clr_busy_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [1:0]          s1_src_q, s1_src_d, s2_src_q;
  logic                s1_wr_q, s1_wr_d, s2_wr_q;
  logic [7:0]          s1_bank_q, s1_bank_d, s2_bank_q;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_din_q, mem_din_d;
  logic [NPLANE-1:0]   mem_we_q, mem_we_d;
  logic                vdp_ok, cpu_ok, cpu_boost;
  logic [1:0]          gnt;
  logic [7:0]          rd_byte;
  logic                unused_bank_bits;
  // a requester with an issued but un-acked access sits out arbitration
  assign vdp_ok = vdp_req & ~vdp_out_q;
  assign cpu_ok = cpu_req & ~cpu_out_q;
`ifdef SCHED_FAIR_EN
  logic [1:0] starve_q, starve_d;
  // after three lost slots in a row the CPU outranks the clear sweep (never the VDP)
  assign cpu_boost = cpu_ok & (starve_q == 2'd3);
  assign starve_d  = (!cpu_ok || gnt == SRC_CPU) ? 2'd0 : (starve_q == 2'd3) ? starve_q : starve_q + 2'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) starve_q <= 2'd0;
    else          starve_q <= starve_d;
`else
  assign cpu_boost = 1'b0;
`endif
  assign gnt = vdp_ok ? SRC_VDP : cpu_boost ? SRC_CPU : clr_busy_q ? SRC_CLR : cpu_ok ? SRC_CPU : SRC_NONE;
  always_comb begin
    vdp_out_d  = (gnt == SRC_VDP) ? 1'b1 : (s2_src_q == SRC_VDP) ? 1'b0 : vdp_out_q;
    cpu_out_d  = (gnt == SRC_CPU) ? 1'b1 : (s2_src_q == SRC_CPU) ? 1'b0 : cpu_out_q;
    // a restart wins over the last-address shutdown; the current grant still uses the old counter
    clr_busy_d = clr_start ? 1'b1 : (gnt == SRC_CLR && clr_cnt_q == '1) ? 1'b0 : clr_busy_q;
    clr_cnt_d  = clr_start ? '0 : (gnt == SRC_CLR) ? clr_cnt_q + ADDR_W'(1) : clr_cnt_q;
    s1_src_d   = gnt;
    s1_wr_d    = cpu_wr;
    s1_bank_d  = rd_bank;
    mem_addr_d = (gnt == SRC_VDP) ? vdp_addr : (gnt == SRC_CPU) ? cpu_addr : (gnt == SRC_CLR) ? clr_cnt_q : mem_addr_q;
    mem_din_d  = (gnt == SRC_CPU) ? cpu_din : (gnt == SRC_CLR) ? CLR_VAL : mem_din_q;
    mem_we_d   = (gnt == SRC_CLR) ? '1 : (gnt == SRC_CPU && cpu_wr) ? wr_bank[NPLANE-1:0] : '0;
  end
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NPLANE; i++)
      if (s2_bank_q == 8'(i + 1)) rd_byte = mem_q[8*i +: 8];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vdp_out_q  <= 1'b0;
      cpu_out_q  <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_cnt_q  <= '0;
      s1_src_q   <= SRC_NONE;
      s1_wr_q    <= 1'b0;
      s1_bank_q  <= 8'h00;
      s2_src_q   <= SRC_NONE;
      s2_wr_q    <= 1'b0;
      s2_bank_q  <= 8'h00;
      mem_addr_q <= '0;
      mem_din_q  <= 8'h00;
      mem_we_q   <= '0;
    end else begin
      vdp_out_q  <= vdp_out_d;
      cpu_out_q  <= cpu_out_d;
      clr_busy_q <= clr_busy_d;
      clr_cnt_q  <= clr_cnt_d;
      s1_src_q   <= s1_src_d;
      s1_wr_q    <= s1_wr_d;
      s1_bank_q  <= s1_bank_d;
      s2_src_q   <= s1_src_q;
      s2_wr_q    <= s1_wr_q;
      s2_bank_q  <= s1_bank_q;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
    end
  assign unused_bank_bits = ^wr_bank;
  assign vdp_ack  = (s2_src_q == SRC_VDP);
  assign cpu_ack  = (s2_src_q == SRC_CPU);
  assign vdp_data = vdp_ack ? mem_q : '0;
  assign cpu_dout = (cpu_ack && !s2_wr_q) ? rd_byte : 8'h00;
  assign clr_busy = clr_busy_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
endmodule
